// File: rtl/fpga_pkg.sv
// rtl/fpga_pkg.sv - shared widths, frame layout and state encoding for the bus master
package fpga_pkg;

    localparam int FRAME_LEN = 77;
    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 4;
    localparam int CRC_W     = 4;
    localparam int CNT_W     = 7;

    // Frame field positions, MSB is transmitted first
    localparam int START_BIT   = 76;
    localparam int SENDER_HI   = 75;
    localparam int SENDER_LO   = 72;
    localparam int RECEIVER_HI = 71;
    localparam int RECEIVER_LO = 68;
    localparam int DATA_HI     = 67;
    localparam int DATA_LO     = 4;
    localparam int CRC_HI      = 3;
    localparam int CRC_LO      = 0;

    // Count value reached after F[0] has been driven; that cycle is the idle gap
    localparam logic [CNT_W-1:0] GAP_COUNT = CNT_W'(FRAME_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic [ADDR_W-1:0] sender,
        input logic [ADDR_W-1:0] receiver,
        input logic [DATA_W-1:0] data,
        input logic [CRC_W-1:0]  crc
    );
        logic [FRAME_LEN-1:0] f;
        f                         = '0;
        f[START_BIT]              = 1'b1;
        f[SENDER_HI:SENDER_LO]    = sender;
        f[RECEIVER_HI:RECEIVER_LO] = receiver;
        f[DATA_HI:DATA_LO]        = data;
        f[CRC_HI:CRC_LO]          = crc;
        return f;
    endfunction

endpackage

// File: rtl/fpga_frame_serializer.sv
// rtl/fpga_frame_serializer.sv - loads a 77-bit frame and shifts it out MSB-first with a one-bit idle gap
module frame_serializer
    import fpga_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [FRAME_LEN-1:0] frame,
    output logic                 bus_out
);

    state_t               state;
    state_t               state_next;
    logic [FRAME_LEN-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic                 load;
    logic                 shift;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: every IDLE cycle starts a frame; SEND ends after the gap cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = SEND;
            SEND:    state_next = (cnt == GAP_COUNT) ? IDLE : SEND;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: load in IDLE, shift while frame bits remain, otherwise drive the gap
    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        case (state)
            IDLE:    load  = 1'b1;
            SEND:    shift = (cnt != GAP_COUNT);
            default: ;
        endcase
    end

    // Datapath: start bit goes straight to the line on load, the rest follows from the shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg   <= '0;
            cnt     <= '0;
            bus_out <= 1'b0;
        end else if (load) begin
            shreg   <= {frame[FRAME_LEN-2:0], 1'b0};
            cnt     <= CNT_W'(1);
            bus_out <= frame[FRAME_LEN-1];
        end else if (shift) begin
            shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
            cnt     <= cnt + CNT_W'(1);
            bus_out <= shreg[FRAME_LEN-1];
        end else begin
            cnt     <= '0;
            bus_out <= 1'b0;
        end
    end

endmodule

// File: rtl/fpga.sv
// rtl/fpga.sv - 16-node shared serial bus master: node select, frame assembly, serializer
module fpga
    import fpga_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [CRC_W-1:0]  CRC1,
    input  logic [CRC_W-1:0]  CRC2,
    input  logic [CRC_W-1:0]  CRC3,
    input  logic [CRC_W-1:0]  CRC4,
    input  logic [CRC_W-1:0]  CRC5,
    input  logic [CRC_W-1:0]  CRC6,
    input  logic [CRC_W-1:0]  CRC7,
    input  logic [CRC_W-1:0]  CRC8,
    input  logic [CRC_W-1:0]  CRC9,
    input  logic [CRC_W-1:0]  CRC10,
    input  logic [CRC_W-1:0]  CRC11,
    input  logic [CRC_W-1:0]  CRC12,
    input  logic [CRC_W-1:0]  CRC13,
    input  logic [CRC_W-1:0]  CRC14,
    input  logic [CRC_W-1:0]  CRC15,
    input  logic [CRC_W-1:0]  CRC16,
    input  logic [DATA_W-1:0] Data1,
    input  logic [DATA_W-1:0] Data2,
    input  logic [DATA_W-1:0] Data3,
    input  logic [DATA_W-1:0] Data4,
    input  logic [DATA_W-1:0] Data5,
    input  logic [DATA_W-1:0] Data6,
    input  logic [DATA_W-1:0] Data7,
    input  logic [DATA_W-1:0] Data8,
    input  logic [DATA_W-1:0] Data9,
    input  logic [DATA_W-1:0] Data10,
    input  logic [DATA_W-1:0] Data11,
    input  logic [DATA_W-1:0] Data12,
    input  logic [DATA_W-1:0] Data13,
    input  logic [DATA_W-1:0] Data14,
    input  logic [DATA_W-1:0] Data15,
    input  logic [DATA_W-1:0] Data16,
    input  logic [ADDR_W-1:0] receiverAddr1,
    input  logic [ADDR_W-1:0] receiverAddr2,
    input  logic [ADDR_W-1:0] receiverAddr3,
    input  logic [ADDR_W-1:0] receiverAddr4,
    input  logic [ADDR_W-1:0] receiverAddr5,
    input  logic [ADDR_W-1:0] receiverAddr6,
    input  logic [ADDR_W-1:0] receiverAddr7,
    input  logic [ADDR_W-1:0] receiverAddr8,
    input  logic [ADDR_W-1:0] receiverAddr9,
    input  logic [ADDR_W-1:0] receiverAddr10,
    input  logic [ADDR_W-1:0] receiverAddr11,
    input  logic [ADDR_W-1:0] receiverAddr12,
    input  logic [ADDR_W-1:0] receiverAddr13,
    input  logic [ADDR_W-1:0] receiverAddr14,
    input  logic [ADDR_W-1:0] receiverAddr15,
    input  logic [ADDR_W-1:0] receiverAddr16,
    input  logic [ADDR_W-1:0] mod,
    output logic              bus_out
);

    logic [CRC_W-1:0]     crc_nodes  [16];
    logic [DATA_W-1:0]    data_nodes [16];
    logic [ADDR_W-1:0]    addr_nodes [16];
    logic [CRC_W-1:0]     sel_crc;
    logic [DATA_W-1:0]    sel_data;
    logic [ADDR_W-1:0]    sel_addr;
    logic [FRAME_LEN-1:0] frame;

    // Index 0 is node 1, matching the mod encoding
    assign crc_nodes  = '{CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                          CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16};
    assign data_nodes = '{Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
                          Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16};
    assign addr_nodes = '{receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
                          receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
                          receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
                          receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16};

    // Bus-owner mux and frame assembly; the serializer only samples this on its load cycle
    always_comb begin
        sel_crc  = crc_nodes[mod];
        sel_data = data_nodes[mod];
        sel_addr = addr_nodes[mod];
        frame    = build_frame(mod, sel_addr, sel_data, sel_crc);
    end

    frame_serializer u_serializer (
        .clock   (clock),
        .reset   (reset),
        .frame   (frame),
        .bus_out (bus_out)
    );

endmodule

// File: tb/tb_fpga.sv
// tb/tb_fpga.sv - scoreboard bench for the 16-node serial bus master
module tb_fpga;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  crc  [16];
    logic [63:0] data [16];
    logic [3:0]  addr [16];
    logic [3:0]  mod;
    logic        bus_out;

    logic        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    fpga dut (
        .clock(clock), .reset(reset),
        .CRC1(crc[0]),   .CRC2(crc[1]),   .CRC3(crc[2]),   .CRC4(crc[3]),
        .CRC5(crc[4]),   .CRC6(crc[5]),   .CRC7(crc[6]),   .CRC8(crc[7]),
        .CRC9(crc[8]),   .CRC10(crc[9]),  .CRC11(crc[10]), .CRC12(crc[11]),
        .CRC13(crc[12]), .CRC14(crc[13]), .CRC15(crc[14]), .CRC16(crc[15]),
        .Data1(data[0]),   .Data2(data[1]),   .Data3(data[2]),   .Data4(data[3]),
        .Data5(data[4]),   .Data6(data[5]),   .Data7(data[6]),   .Data8(data[7]),
        .Data9(data[8]),   .Data10(data[9]),  .Data11(data[10]), .Data12(data[11]),
        .Data13(data[12]), .Data14(data[13]), .Data15(data[14]), .Data16(data[15]),
        .receiverAddr1(addr[0]),   .receiverAddr2(addr[1]),   .receiverAddr3(addr[2]),
        .receiverAddr4(addr[3]),   .receiverAddr5(addr[4]),   .receiverAddr6(addr[5]),
        .receiverAddr7(addr[6]),   .receiverAddr8(addr[7]),   .receiverAddr9(addr[8]),
        .receiverAddr10(addr[9]),  .receiverAddr11(addr[10]), .receiverAddr12(addr[11]),
        .receiverAddr13(addr[12]), .receiverAddr14(addr[13]), .receiverAddr15(addr[14]),
        .receiverAddr16(addr[15]),
        .mod(mod), .bus_out(bus_out)
    );

    // Expected line sequence for one frame: start, sender, receiver, data, crc, then the idle gap
    task automatic push_frame(input logic [3:0] s, input logic [3:0] r,
                              input logic [63:0] d, input logic [3:0] c);
        logic [76:0] f;
        f = {1'b1, s, r, d, c};
        for (int i = 76; i >= 0; i--) exp_q.push_back(f[i]);
        exp_q.push_back(1'b0);
    endtask

    task automatic check_bits(input int n, input string tag);
        logic e;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL %s bit %0d: scoreboard empty, observed %b", tag, i, bus_out);
            end else begin
                e = exp_q.pop_front();
                assert (bus_out === e) else begin
                    errors++;
                    $error("FAIL %s bit %0d: observed %b expected %b", tag, i, bus_out, e);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mod   = 4'd0;
        for (int n = 0; n < 16; n++) begin
            crc[n]  = 4'(n);
            addr[n] = 4'(15 - n);
            data[n] = {16{4'(n)}};
        end

        // Reset held for 5 edges: line stays low
        repeat (5) exp_q.push_back(1'b0);
        check_bits(5, "reset_hold");

        // Node 1 frame, starting at the first edge after release, then its repeat
        mod = 4'd0; data[0] = 64'd1; crc[0] = 4'd1; addr[0] = 4'd1;
        reset = 1'b0;
        push_frame(4'd0, 4'd1, 64'd1, 4'd1);
        check_bits(78, "node1");
        push_frame(4'd0, 4'd1, 64'd1, 4'd1);
        check_bits(78, "node1_repeat");

        // Node 16 select; other nodes carry distinct values that must not leak
        mod = 4'd15; data[15] = 64'hFFFF_FFFF_FFFF_FFFF; crc[15] = 4'hA; addr[15] = 4'h5;
        push_frame(4'hF, 4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA);
        check_bits(78, "node16");

        // Mid-frame change of mod and Data1 only affects the following frame
        mod = 4'd0; data[0] = 64'h0123_4567_89AB_CDEF; crc[0] = 4'h6; addr[0] = 4'h9;
        data[1] = 64'hDEAD_BEEF_0BAD_F00D; crc[1] = 4'h3; addr[1] = 4'hC;
        push_frame(4'd0, 4'h9, 64'h0123_4567_89AB_CDEF, 4'h6);
        check_bits(20, "midchange_head");
        mod = 4'd1; data[0] = 64'h5555_AAAA_5555_AAAA;
        check_bits(58, "midchange_tail");
        push_frame(4'd1, 4'hC, 64'hDEAD_BEEF_0BAD_F00D, 4'h3);
        check_bits(78, "node2_next");

        // Bit order: data MSB at E0+9, LSB at E0+72
        mod = 4'd2; data[2] = 64'h8000_0000_0000_0001; crc[2] = 4'h0; addr[2] = 4'h0;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        repeat (4) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        repeat (62) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        repeat (5) exp_q.push_back(1'b0);
        check_bits(78, "bit_order");

        // Reset at cycle 30 of a frame aborts it; a full frame restarts after release
        mod = 4'd3; data[3] = 64'hCAFE_F00D_1234_5678; crc[3] = 4'h7; addr[3] = 4'hE;
        push_frame(4'd3, 4'hE, 64'hCAFE_F00D_1234_5678, 4'h7);
        check_bits(30, "abort_head");
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back(1'b0);
        check_bits(1, "abort_reset");
        reset = 1'b0;
        push_frame(4'd3, 4'hE, 64'hCAFE_F00D_1234_5678, 4'h7);
        check_bits(78, "abort_restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpga.md
# fpga

Shared serial bus transmitter for a 16-node system. Each node presents a 64-bit payload, a 4-bit receiver address and a 4-bit CRC. The 4-bit `mod` input selects the node that owns the bus. The block packs the selected node's fields into a fixed 77-bit frame and shifts it out MSB-first on the single-wire `bus_out`, repeating continuously. It is the top-level bus master of the FPGA project.

## Interface
Parameters: none. Widths are fixed by the shared package.
- `clock` in 1 — single system clock; all state changes on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `CRC1`..`CRC16` in 4 each — per-node CRC nibble, sent verbatim; no CRC is computed or checked here.
- `Data1`..`Data16` in 64 each — per-node payload.
- `receiverAddr1`..`receiverAddr16` in 4 each — per-node destination address.
- `mod` in 4 — bus-owner select; value k selects node k+1 (0 → node 1, 15 → node 16).
- `bus_out` out 1 — registered serial bus line; 0 when idle.

## Operation
- Frame F[76:0], sent from bit 76 down to bit 0:
  - F[76] = start bit, always 1.
  - F[75:72] = sender address, equal to the latched `mod`.
  - F[71:68] = `receiverAddrN`.
  - F[67:4] = `DataN`, bit 63 first.
  - F[3:0] = `CRCN`, bit 3 first.
- States:
  - IDLE — reset state, `bus_out` = 0.
  - SEND — counter 1..76.
- IDLE, next edge:
  - Sample `mod` and the selected node's fields into a 77-bit shift register.
  - Set `bus_out` to F[76] = 1, counter to 1, and go to SEND.
- SEND, counter i in 1..76: `bus_out` ← F[76−i], counter increments.
- After F[0] has been driven, next edge: `bus_out` ← 0, go to IDLE.
- Inputs are latched only on the IDLE→SEND edge. Changes to `mod`, Data, CRC or addresses mid-frame affect only the next frame.
- No arbitration, handshake or acknowledge. Transmission repeats forever while `reset` is low.

## Timing
- Reset:
  - `reset` high at an edge forces IDLE, counter 0, shift register 0 and `bus_out` 0 on that edge.
  - Reset asserted mid-frame aborts the frame immediately.
- E0 is the first rising edge with `reset` low. At E0, `bus_out` becomes 1 (start bit).
- Edge E0+j (j = 0..76) drives F[76−j]. Edge E0+77 drives 0 (idle gap).
- E0+78 starts the next frame. Frame period is 78 cycles: 77 data bits plus 1 idle bit.
- Latency from `mod`/input sample to first payload bit (F[67]) is 9 edges after the sampling edge.

## Structure
- Shared package `fpga_pkg` holds:
  - `FRAME_LEN` = 77, `DATA_W` = 64, `ADDR_W` = 4, `CRC_W` = 4.
  - Field offsets (start 76, sender 75:72, receiver 71:68, data 67:4, crc 3:0).
  - State enum {IDLE, SEND}.
- Sub-module `frame_serializer`:
  - Input: 77-bit frame.
  - Contains the load strobe, shift register, counter, FSM and `bus_out` register.
- The top level holds the 16-way combinational node mux indexed by `mod` and the frame assembly.

## Test plan
- Reset and idle:
  - Hold `reset` high for 5 edges → `bus_out` = 0 throughout.
  - Assert `reset` at cycle 30 of a frame → `bus_out` = 0 on that edge, and a full frame restarts at the first edge after release.
- Node 1 frame:
  - Inputs: `mod`=0, `Data1`=1, `CRC1`=1, `receiverAddr1`=1.
  - Expected `bus_out` from E0: 1, 0000, 0001, 63 zeros, 1, 0001, then 0 at E0+77.
  - Start bit repeats at E0+78.
- Node 16 select:
  - Inputs: `mod`=15, `Data16`=64'hFFFF_FFFF_FFFF_FFFF, `CRC16`=4'hA, `receiverAddr16`=4'h5.
  - Expected bits: 1, 1111, 0101, 64 ones, 1010.
  - Other nodes' fields must not appear.
- Mid-frame change:
  - Switch `mod` 0→1 and change `Data1` at E0+20 → current frame unchanged.
  - Next frame (E0+78) carries sender 0001 and node 2's fields.
- Bit order: `Data3`=64'h8000_0000_0000_0001 with `mod`=2 → `bus_out` = 1 at E0+9 and E0+72, 0 at E0+10..E0+71.
